// File: rtl/cell_checker_pkg.sv
// Shared types and helpers for the standard-cell response checker.
// Holds the FSM encoding, mismatch-vector bit positions and the combinational golden functions.
package cell_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int NUM_CELLS = 6;
    localparam int BIT_NAND  = 0;
    localparam int BIT_NOR   = 1;
    localparam int BIT_NOT   = 2;
    localparam int BIT_MUX   = 3;
    localparam int BIT_QP    = 4;
    localparam int BIT_QN    = 5;

    function automatic logic [3:0] golden_comb(input logic a, input logic b,
                                               input logic sel, input logic enb);
        logic [3:0] g;
        g           = '0;
        g[BIT_NAND] = ~(a & b);
        g[BIT_NOR]  = ~(a | b);
        g[BIT_NOT]  = ~a;
        g[BIT_MUX]  = enb & (sel ? b : a);
        return g;
    endfunction

endpackage

// File: rtl/cell_checker_if.sv
// Stimulus, cell-response and result signals of the cell checker.
// The master side drives stimulus and cell outputs; the checker is the slave.
interface cell_checker_if #(
    parameter int N_SAMPLES = 64,
    parameter int CNT_W     = 8
);
    localparam int IDX_W = $clog2(N_SAMPLES);

    logic             start;
    logic             a;
    logic             b;
    logic             d;
    logic             sel;
    logic             enb;
    logic             clr;
    logic             pre;
    logic             y_nand;
    logic             y_nor;
    logic             y_not;
    logic             y_mux;
    logic             qp;
    logic             qn;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic [5:0]       err_mask;
    logic [IDX_W-1:0] first_fail;

    modport master (
        output start, a, b, d, sel, enb, clr, pre,
        output y_nand, y_nor, y_not, y_mux, qp, qn,
        input  busy, done, pass, err_cnt, err_mask, first_fail
    );

    modport slave (
        input  start, a, b, d, sel, enb, clr, pre,
        input  y_nand, y_nor, y_not, y_mux, qp, qn,
        output busy, done, pass, err_cnt, err_mask, first_fail
    );
endinterface

// File: rtl/cell_checker_golden.sv
// Golden reference for the cells: combinational functions plus a model of the ffd.
// Produces the per-cell mismatch vector for the current stimulus and observed outputs.
module cell_checker_golden
    import cell_checker_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 check,
    input  logic                 a,
    input  logic                 b,
    input  logic                 d,
    input  logic                 sel,
    input  logic                 enb,
    input  logic                 clr,
    input  logic                 pre,
    input  logic [NUM_CELLS-1:0] obs,
    output logic [NUM_CELLS-1:0] mis
);
    logic       exp_q;
    logic       exp_vld;
    logic [3:0] gold;

    // FF bits stay quiet until the model has seen one sample of the window.
    always_comb begin
        gold        = golden_comb(a, b, sel, enb);
        mis         = '0;
        mis[3:0]    = obs[3:0] ^ gold;
        mis[BIT_QP] = exp_vld & (obs[BIT_QP] != exp_q);
        mis[BIT_QN] = exp_vld & (obs[BIT_QN] != ~exp_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q   <= 1'b0;
            exp_vld <= 1'b0;
        end else if (clear) begin
            exp_vld <= 1'b0;
        end else if (check) begin
            exp_q   <= clr ? 1'b0 : (pre ? 1'b1 : d);
            exp_vld <= 1'b1;
        end
    end
endmodule

// File: rtl/cell_checker.sv
// Response monitor comparing cell outputs against golden values over a fixed sample window.
// Reports sticky per-cell fail bits, a saturating error count and the first failing sample.
//   state    | meaning
//   ST_IDLE  | waiting for start after reset
//   ST_CHECK | comparing one sample per clock, N_SAMPLES samples
//   ST_DONE  | results held; start launches a fresh window
module cell_checker
    import cell_checker_pkg::*;
#(
    parameter int N_SAMPLES = 64,
    parameter int CNT_W     = 8
) (
    input logic           clk,
    input logic           rst,
    cell_checker_if.slave bus
);
    localparam int               IDX_W    = $clog2(N_SAMPLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t                 state;
    state_t                 state_nxt;
    logic                   enter;
    logic [IDX_W-1:0]       idx;
    logic [CNT_W-1:0]       err_cnt;
    logic [NUM_CELLS-1:0]   err_mask;
    logic [IDX_W-1:0]       first_fail;
    logic [NUM_CELLS-1:0]   obs;
    logic [NUM_CELLS-1:0]   mis;

    assign obs = {bus.qn, bus.qp, bus.y_mux, bus.y_not, bus.y_nor, bus.y_nand};

    cell_checker_golden u_golden (
        .clk   (clk),
        .rst   (rst),
        .clear (enter),
        .check (state == ST_CHECK),
        .a     (bus.a),
        .b     (bus.b),
        .d     (bus.d),
        .sel   (bus.sel),
        .enb   (bus.enb),
        .clr   (bus.clr),
        .pre   (bus.pre),
        .obs   (obs),
        .mis   (mis)
    );

    always_comb begin
        state_nxt = state;
        enter     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_nxt = ST_CHECK;
                    enter     = 1'b1;
                end
            end
            ST_CHECK: begin
                if (idx == IDX_LAST) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            err_cnt    <= '0;
            err_mask   <= '0;
            first_fail <= '0;
        end else begin
            state <= state_nxt;
            if (enter) begin
                idx        <= '0;
                err_cnt    <= '0;
                err_mask   <= '0;
                first_fail <= '0;
            end else if (state == ST_CHECK) begin
                if (idx != IDX_LAST) idx <= idx + 1'b1;
                // An empty mask means no earlier sample of this window has failed.
                if (|mis) begin
                    err_mask <= err_mask | mis;
                    if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
                    if (err_mask == '0) first_fail <= idx;
                end
            end
        end
    end

    assign bus.busy       = (state == ST_CHECK);
    assign bus.done       = (state == ST_DONE);
    assign bus.pass       = (state == ST_DONE) && (err_cnt == '0);
    assign bus.err_cnt    = err_cnt;
    assign bus.err_mask   = err_mask;
    assign bus.first_fail = first_fail;
endmodule

// File: tb/tb_cell_checker.sv
// Self-checking bench for cell_checker: directed window table plus randomized fault windows.
// Two instances (8-bit and 4-bit error counters) see identical stimulus.
module tb_cell_checker;
    localparam int N = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start, a, b, d, sel, enb, clr, pre;
    logic [5:0] obs;
    logic       ffq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int mode;
        int mask;
        int cnt;
        int first;
    } vec_t;
    vec_t tbl[6];

    cell_checker_if #(.N_SAMPLES(N), .CNT_W(8)) bus8 ();
    cell_checker_if #(.N_SAMPLES(N), .CNT_W(4)) bus4 ();

    assign {bus8.start, bus8.a, bus8.b, bus8.d, bus8.sel, bus8.enb, bus8.clr, bus8.pre} =
           {start, a, b, d, sel, enb, clr, pre};
    assign {bus4.start, bus4.a, bus4.b, bus4.d, bus4.sel, bus4.enb, bus4.clr, bus4.pre} =
           {start, a, b, d, sel, enb, clr, pre};
    assign {bus8.qn, bus8.qp, bus8.y_mux, bus8.y_not, bus8.y_nor, bus8.y_nand} = obs;
    assign {bus4.qn, bus4.qp, bus4.y_mux, bus4.y_not, bus4.y_nor, bus4.y_nand} = obs;

    cell_checker #(.N_SAMPLES(N), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    cell_checker #(.N_SAMPLES(N), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    always #5 clk = ~clk;

    // A healthy ffd feeding the checker.
    always @(posedge clk) begin
        if (rst) ffq <= 1'b0;
        else     ffq <= clr ? 1'b0 : (pre ? 1'b1 : d);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},  int'(bus8.busy), 0);
        chk({tag, "_done"},  int'(bus8.done), 0);
        chk({tag, "_pass"},  int'(bus8.pass), 0);
        chk({tag, "_cnt8"},  int'(bus8.err_cnt), 0);
        chk({tag, "_mask"},  int'(bus8.err_mask), 0);
        chk({tag, "_first"}, int'(bus8.first_fail), 0);
        chk({tag, "_cnt4"},  int'(bus4.err_cnt), 0);
        chk({tag, "_busy4"}, int'(bus4.busy), 0);
    endtask

    // mode: 0 clean, 1 nand flip @5, 2 qn=qp from 10, 3 mux flipped, 4 random flips,
    //       5 clr=pre=d=1, 6 start noise during the window
    task automatic run_window(input int mode, input int rst_at);
        int         nfail;
        int         first_m;
        logic [5:0] mask_m;
        logic [5:0] gold;
        logic [5:0] mis;
        logic       p_d, p_clr, p_pre, expq;
        nfail   = 0;
        first_m = 0;
        mask_m  = '0;
        p_d = 1'b0; p_clr = 1'b0; p_pre = 1'b0;

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk("busy", int'(bus8.busy), 1);
            chk("run_cnt8", int'(bus8.err_cnt), sat(nfail, 8));
            chk("run_cnt4", int'(bus4.err_cnt), sat(nfail, 4));
            if (k == 0) chk("done_drop", int'(bus8.done), 0);
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_zero("mid_rst");
                return;
            end
            a   = 1'($urandom);
            b   = 1'($urandom);
            d   = 1'($urandom);
            sel = 1'($urandom);
            enb = 1'($urandom);
            clr = ($urandom % 8 == 0);
            pre = ($urandom % 8 == 0);
            if (mode == 5) {clr, pre, d} = 3'b111;
            start = (mode == 6) ? 1'($urandom) : 1'b0;

            gold[0] = ~(a & b);
            gold[1] = ~(a | b);
            gold[2] = ~a;
            gold[3] = enb ? (sel ? b : a) : 1'b0;
            gold[4] = ffq;
            gold[5] = ~ffq;
            obs = gold;
            case (mode)
                1: if (k == 5) obs[0] = ~obs[0];
                2: if (k >= 10) obs[5] = obs[4];
                3: obs[3] = ~obs[3];
                4: if ($urandom % 6 == 0) obs = obs ^ 6'(1 << ($urandom % 6));
                default: ;
            endcase

            mis = obs ^ gold;
            mis[5:4] = 2'b00;
            if (k > 0) begin
                expq   = p_clr ? 1'b0 : (p_pre ? 1'b1 : p_d);
                mis[4] = (obs[4] != expq);
                mis[5] = (obs[5] != ~expq);
            end
            if (mis != 0) begin
                if (nfail == 0) first_m = k;
                nfail++;
                mask_m |= mis;
            end
            p_d = d; p_clr = clr; p_pre = pre;
            @(negedge clk);
        end
        start = 1'b0;
        chk("end_busy",   int'(bus8.busy), 0);
        chk("end_done",   int'(bus8.done), 1);
        chk("end_pass",   int'(bus8.pass), (nfail == 0) ? 1 : 0);
        chk("end_cnt8",   int'(bus8.err_cnt), sat(nfail, 8));
        chk("end_mask",   int'(bus8.err_mask), int'(mask_m));
        chk("end_first",  int'(bus8.first_fail), first_m);
        chk("end_cnt4",   int'(bus4.err_cnt), sat(nfail, 4));
        chk("end_mask4",  int'(bus4.err_mask), int'(mask_m));
        chk("end_first4", int'(bus4.first_fail), first_m);
        chk("end_pass4",  int'(bus4.pass), (nfail == 0) ? 1 : 0);
    endtask

    initial begin
        tbl = '{'{0, 6'h00,  0,  0},
                '{1, 6'h01,  1,  5},
                '{2, 6'h20, 54, 10},
                '{3, 6'h08, 64,  0},
                '{5, 6'h00,  0,  0},
                '{6, 6'h00,  0,  0}};
        start = 1'b0; a = 1'b0; b = 1'b0; d = 1'b0;
        sel = 1'b0; enb = 1'b0; clr = 1'b0; pre = 1'b0;
        obs = 6'b100111;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_window(tbl[i].mode, -1);
            chk("tbl_mask",  int'(bus8.err_mask), tbl[i].mask);
            chk("tbl_cnt8",  int'(bus8.err_cnt), tbl[i].cnt);
            chk("tbl_cnt4",  int'(bus4.err_cnt), sat(tbl[i].cnt, 4));
            chk("tbl_first", int'(bus8.first_fail), tbl[i].first);
            chk("tbl_pass",  int'(bus8.pass), (tbl[i].cnt == 0) ? 1 : 0);
            @(negedge clk);
            chk("done_held", int'(bus8.done), 1);
        end

        repeat (4) run_window(4, -1);

        run_window(0, 20);
        @(negedge clk);
        check_zero("idle_after_rst");
        run_window(0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
